// File: rtl/pacman_draw_sequencer_if.sv
// Command/status bundle between the frame sequencer and the pacman sprite
// controller. The sequencer is the master: it issues pass and load commands
// and reads back pass completion and the current sprite position.
interface pacman_draw_sequencer_if;
  logic       draw;
  logic       clear;
  logic       shift_h;
  logic       shift_v;
  logic       load;
  logic [6:0] shift_amount;
  logic [7:0] load_x;
  logic [6:0] load_y;
  logic       complete;
  logic [7:0] posx;
  logic [6:0] posy;

  modport master (
    output draw, clear, shift_h, shift_v, load, shift_amount, load_x, load_y,
    input  complete, posx, posy
  );

  modport slave (
    input  draw, clear, shift_h, shift_v, load, shift_amount, load_x, load_y,
    output complete, posx, posy
  );
endinterface

// File: rtl/pacman_draw_sequencer.sv
// Frame-level command initiator for the pacman sprite controller. Each frame
// tick runs: erase pass at the old position, compute a clamped step from the
// latched joystick direction, load the new position, redraw. Every pass is
// guarded by a cycle budget so a stuck controller cannot hang the frame.
module pacman_draw_sequencer #(
  parameter int X_MAX        = 160,
  parameter int Y_MAX        = 120,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int STEP         = 1,
  parameter int PASS_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick_i,
  input  logic [1:0]               dir_i,
  input  logic                     dir_valid_i,
  pacman_draw_sequencer_if.master  spr,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     overrun_o,
  output logic                     timeout_err_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ERASE_ARM = 3'd1;
  localparam logic [2:0] S_ERASE     = 3'd2;
  localparam logic [2:0] S_CALC      = 3'd3;
  localparam logic [2:0] S_LOAD      = 3'd4;
  localparam logic [2:0] S_DRAW_ARM  = 3'd5;
  localparam logic [2:0] S_DRAW      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int             CW       = $clog2(PASS_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PASS_TIMEOUT - 1);
  localparam logic [8:0]     X_LIM    = 9'(X_MAX - SPRITE_W);
  localparam logic [8:0]     Y_LIM    = 9'(Y_MAX - SPRITE_H);
  localparam logic [8:0]     STEP9    = 9'(STEP);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic [1:0]    dir_q, dir_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    load_x_q, load_x_d;
  logic [6:0]    load_y_q, load_y_d;
  logic          draw_q, clear_q, shift_h_q, load_q, busy_q, frame_done_q;

  // One step along an axis in 9-bit arithmetic: decrement floors at 0,
  // increment saturates at the axis limit.
  function automatic logic [8:0] step_pos(input logic [8:0] p,
                                          input logic       inc,
                                          input logic [8:0] lim);
    logic [8:0] r;
    if (inc) begin
      r = p + STEP9;
      if (r > lim) begin
        r = lim;
      end else begin
        r = r;
      end
    end else begin
      if (p < STEP9) begin
        r = 9'd0;
      end else begin
        r = p - STEP9;
      end
    end
    return r;
  endfunction

  // Next-state logic: frame sequencing, pass budget, tick bookkeeping, new position.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    load_x_d  = load_x_q;
    load_y_d  = load_y_q;
    dir_d     = dir_valid_i ? dir_i : dir_q;

    // A tick while busy is remembered once; a further one is an overrun.
    if (frame_tick_i && (state_q != S_IDLE)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_d;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick_i || pending_q) begin
          state_d   = S_ERASE_ARM;
          pending_d = 1'b0;
          cnt_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERASE_ARM, S_DRAW_ARM: begin
        cnt_d = cnt_q + 1'b1;
        if (!spr.complete) begin
          state_d = (state_q == S_ERASE_ARM) ? S_ERASE : S_DRAW;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = (state_q == S_ERASE_ARM) ? S_CALC : S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_ERASE, S_DRAW: begin
        cnt_d = cnt_q + 1'b1;
        if (spr.complete) begin
          state_d = (state_q == S_ERASE) ? S_CALC : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = (state_q == S_ERASE) ? S_CALC : S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_CALC: begin
        // Uses the registered direction, so a same-cycle dir_valid waits a frame.
        state_d  = S_LOAD;
        load_x_d = spr.posx;
        load_y_d = spr.posy;
        case (dir_q)
          2'd0:    load_y_d = 7'(step_pos({2'b00, spr.posy}, 1'b0, Y_LIM));
          2'd1:    load_y_d = 7'(step_pos({2'b00, spr.posy}, 1'b1, Y_LIM));
          2'd2:    load_x_d = 8'(step_pos({1'b0, spr.posx}, 1'b0, X_LIM));
          2'd3:    load_x_d = 8'(step_pos({1'b0, spr.posx}, 1'b1, X_LIM));
          default: load_x_d = spr.posx;
        endcase
      end
      S_LOAD: begin
        state_d = S_DRAW_ARM;
        cnt_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      dir_q        <= 2'd3;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      load_x_q     <= 8'd0;
      load_y_q     <= 7'd0;
      draw_q       <= 1'b0;
      clear_q      <= 1'b0;
      shift_h_q    <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      dir_q        <= dir_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      load_x_q     <= load_x_d;
      load_y_q     <= load_y_d;
      clear_q      <= (state_d == S_ERASE_ARM) || (state_d == S_ERASE);
      shift_h_q    <= (state_d == S_DRAW_ARM)  || (state_d == S_DRAW);
      draw_q       <= (state_d == S_ERASE_ARM) || (state_d == S_ERASE) ||
                      (state_d == S_DRAW_ARM)  || (state_d == S_DRAW);
      load_q       <= (state_d == S_LOAD);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  assign spr.draw         = draw_q;
  assign spr.clear        = clear_q;
  assign spr.shift_h      = shift_h_q;
  assign spr.shift_v      = 1'b0;
  assign spr.load         = load_q;
  assign spr.shift_amount = 7'd0;
  assign spr.load_x       = load_x_q;
  assign spr.load_y       = load_y_q;
  assign busy_o           = busy_q;
  assign frame_done_o     = frame_done_q;
  assign overrun_o        = overrun_q;
  assign timeout_err_o    = timeout_q;

endmodule

// File: tb/tb_pacman_draw_sequencer.sv
// Directed bench for pacman_draw_sequencer with a behavioural sprite
// controller whose pass length is adjustable (or that never starts a pass).
module tb_pacman_draw_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] dir = 2'd3;
  logic       dir_valid = 1'b0;
  logic       busy, frame_done, overrun, timeout_err;
  logic [7:0] posx_r = 8'd0;
  logic [6:0] posy_r = 7'd0;

  int checks = 0;
  int failures = 0;

  pacman_draw_sequencer_if bus ();

  pacman_draw_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick_i (frame_tick),
    .dir_i        (dir),
    .dir_valid_i  (dir_valid),
    .spr          (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .overrun_o    (overrun),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  // Sprite controller model: complete drops for pass_len cycles once draw is
  // seen, then rises and waits for draw to fall before accepting another pass.
  logic model_complete = 1'b1;
  logic stuck = 1'b0;
  logic running = 1'b0;
  logic wait_low = 1'b0;
  int   pass_len = 511;
  int   mcnt = 0;

  assign bus.complete = model_complete;
  assign bus.posx     = posx_r;
  assign bus.posy     = posy_r;

  always @(posedge clk) begin
    if (stuck) begin
      model_complete <= 1'b1;
      running        <= 1'b0;
      wait_low       <= 1'b0;
    end else if (running) begin
      if (mcnt == pass_len - 1) begin
        model_complete <= 1'b1;
        running        <= 1'b0;
        wait_low       <= 1'b1;
      end
      mcnt <= mcnt + 1;
    end else if (wait_low) begin
      if (!bus.draw) wait_low <= 1'b0;
    end else if (bus.draw) begin
      running        <= 1'b1;
      mcnt           <= 0;
      model_complete <= 1'b0;
    end
  end

  // Event monitor, sampled mid-cycle.
  int n_clr = 0, n_sh = 0, n_load = 0, n_done = 0, n_bad = 0;
  logic [7:0] last_lx = 8'd0;
  logic [6:0] last_ly = 7'd0;

  always @(negedge clk) begin
    if (bus.load) begin
      n_load  = n_load + 1;
      last_lx = bus.load_x;
      last_ly = bus.load_y;
    end
    if (frame_done) n_done = n_done + 1;
    if (bus.draw && bus.clear) n_clr = n_clr + 1;
    if (bus.draw && bus.shift_h) n_sh = n_sh + 1;
    if (bus.draw && (bus.clear == bus.shift_h)) n_bad = n_bad + 1;
    if (bus.draw && bus.load) n_bad = n_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    dir       = d;
    dir_valid = 1'b1;
    tick();
    dir_valid = 1'b0;
  endtask

  // Runs until frame_done is seen, then one more cycle so the monitor has counted it.
  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (frame_done) ok = 1'b1;
    end
    if (ok) tick();
  endtask

  task automatic wait_model_idle();
    for (int i = 0; i < 3000 && (running || wait_low || !model_complete); i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.draw, bus.clear, bus.shift_h, bus.shift_v, bus.load, busy, frame_done, overrun, timeout_err} !== 9'd0) begin
      failures++;
      $display("FAIL reset_flags actual=%b required=0", {bus.draw, bus.clear, bus.shift_h, bus.shift_v, bus.load, busy, frame_done, overrun, timeout_err});
    end
    checks++;
    if (bus.load_x !== 8'd0) begin failures++; $display("FAIL reset_load_x actual=%0d required=0", bus.load_x); end
    checks++;
    if (bus.load_y !== 7'd0) begin failures++; $display("FAIL reset_load_y actual=%0d required=0", bus.load_y); end
    checks++;
    if (bus.shift_amount !== 7'd0) begin failures++; $display("FAIL reset_shift_amount actual=%0d required=0", bus.shift_amount); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    int c0, s0, l0, d0;
    bit ok;
    wait_model_idle();
    pass_len = 511;
    posx_r = 8'd49;
    posy_r = 7'd48;
    c0 = n_clr; s0 = n_sh; l0 = n_load; d0 = n_done;
    pulse_tick();
    checks++;
    if ({bus.draw, bus.clear, bus.shift_h, busy} !== 4'b1101) begin
      failures++; $display("FAIL basic_latency actual=%b required=1101", {bus.draw, bus.clear, bus.shift_h, busy});
    end
    wait_done(3000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done_timeout actual=0 required=1"); end
    checks++;
    if (n_clr - c0 !== 513) begin failures++; $display("FAIL basic_erase_cycles actual=%0d required=513", n_clr - c0); end
    checks++;
    if (n_sh - s0 !== 513) begin failures++; $display("FAIL basic_draw_cycles actual=%0d required=513", n_sh - s0); end
    checks++;
    if (n_load - l0 !== 1) begin failures++; $display("FAIL basic_load_count actual=%0d required=1", n_load - l0); end
    checks++;
    if (last_lx !== 8'd50) begin failures++; $display("FAIL basic_load_x actual=%0d required=50", last_lx); end
    checks++;
    if (last_ly !== 7'd48) begin failures++; $display("FAIL basic_load_y actual=%0d required=48", last_ly); end
    checks++;
    if (n_done - d0 !== 1) begin failures++; $display("FAIL basic_done_count actual=%0d required=1", n_done - d0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after actual=%b required=0", busy); end
    checks++;
    if (n_bad !== 0) begin failures++; $display("FAIL basic_cmd_exclusive actual=%0d required=0", n_bad); end
  endtask

  task automatic test_clamp();
    int          px[6] = '{144, 0, 49, 49, 20, 20};
    int          py[6] = '{48, 48, 0, 104, 30, 30};
    logic [1:0]  dv[6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
    int          ex[6] = '{144, 0, 49, 49, 19, 20};
    int          ey[6] = '{48, 48, 0, 104, 30, 31};
    bit ok;
    for (int k = 0; k < 6; k++) begin
      wait_model_idle();
      pass_len = 8;
      set_dir(dv[k]);
      posx_r = 8'(px[k]);
      posy_r = 7'(py[k]);
      pulse_tick();
      wait_done(300, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL clamp_done_%0d actual=0 required=1", k); end
      checks++;
      if (last_lx !== 8'(ex[k])) begin failures++; $display("FAIL clamp_x_%0d actual=%0d required=%0d", k, last_lx, ex[k]); end
      checks++;
      if (last_ly !== 7'(ey[k])) begin failures++; $display("FAIL clamp_y_%0d actual=%0d required=%0d", k, last_ly, ey[k]); end
    end
  endtask

  task automatic test_overrun();
    int d0;
    bit ok, seen;
    wait_model_idle();
    pass_len = 20;
    posx_r = 8'd10;
    posy_r = 7'd10;
    d0 = n_done;
    pulse_tick();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (bus.shift_h) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL overrun_reach_draw actual=0 required=1"); end
    pulse_tick();
    tick();
    pulse_tick();
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag actual=%b required=1", overrun); end
    wait_done(300, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin failures++; $display("FAIL overrun_first_done actual=%b/%b required=1/0", ok, busy); end
    tick();
    checks++;
    if ({bus.draw, bus.clear} !== 2'b11) begin failures++; $display("FAIL overrun_restart actual=%b required=11", {bus.draw, bus.clear}); end
    wait_done(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL overrun_second_done actual=0 required=1"); end
    for (int i = 0; i < 60; i++) tick();
    checks++;
    if (n_done - d0 !== 2 || busy !== 1'b0) begin
      failures++; $display("FAIL overrun_frame_count actual=%0d busy=%b required=2 busy=0", n_done - d0, busy);
    end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky actual=%b required=1", overrun); end
  endtask

  task automatic test_timeout();
    int c0, s0, l0, d0;
    bit ok;
    wait_model_idle();
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_pre actual=%b required=0", timeout_err); end
    stuck = 1'b1;
    c0 = n_clr; s0 = n_sh; l0 = n_load; d0 = n_done;
    pulse_tick();
    wait_done(2600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_done actual=0 required=1"); end
    checks++;
    if (n_clr - c0 !== 1023) begin failures++; $display("FAIL timeout_erase_cycles actual=%0d required=1023", n_clr - c0); end
    checks++;
    if (n_sh - s0 !== 1023) begin failures++; $display("FAIL timeout_draw_cycles actual=%0d required=1023", n_sh - s0); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_flag actual=%b required=1", timeout_err); end
    checks++;
    if (n_load - l0 !== 1 || n_done - d0 !== 1) begin
      failures++; $display("FAIL timeout_load_done actual=%0d/%0d required=1/1", n_load - l0, n_done - d0);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_erase();
    wait_model_idle();
    pass_len = 50;
    pulse_tick();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if ({bus.clear, overrun, timeout_err} !== 3'b111) begin
      failures++; $display("FAIL midreset_pre actual=%b required=111", {bus.clear, overrun, timeout_err});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.draw, bus.clear, bus.shift_h, busy, overrun, timeout_err} !== 6'd0) begin
      failures++; $display("FAIL midreset_outputs actual=%b required=000000", {bus.draw, bus.clear, bus.shift_h, busy, overrun, timeout_err});
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({bus.draw, busy} !== 2'b00) begin failures++; $display("FAIL midreset_idle actual=%b required=00", {bus.draw, busy}); end
  endtask

  task automatic test_dir_midframe();
    bit ok;
    wait_model_idle();
    pass_len = 20;
    set_dir(2'd3);
    posx_r = 8'd49;
    posy_r = 7'd48;
    pulse_tick();
    for (int i = 0; i < 5; i++) tick();
    set_dir(2'd0);
    wait_done(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dirchg_done actual=0 required=1"); end
    checks++;
    if (last_ly !== 7'd47) begin failures++; $display("FAIL dirchg_load_y actual=%0d required=47", last_ly); end
    checks++;
    if (last_lx !== 8'd49) begin failures++; $display("FAIL dirchg_load_x actual=%0d required=49", last_lx); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clamp();
    test_overrun();
    test_timeout();
    test_reset_mid_erase();
    test_dir_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pacman_draw_sequencer.md
# pacman_draw_sequencer

Frame-level command initiator for the pacman sprite controller. Once per frame tick it erases the sprite at its current position, computes a clamped new position from the latched joystick direction, loads it, and redraws the sprite. It drives the sprite controller's draw/clear/shift_h/load command inputs and consumes its complete/posx/posy outputs, so sprite controllers never need their own frame logic. It sits between the game-tick generator and the sprite control module.

## Interface
Parameters:
- X_MAX, 160: screen width in pixels; x positions stay in 0..X_MAX-SPRITE_W.
- Y_MAX, 120: screen height in pixels; y positions stay in 0..Y_MAX-SPRITE_H.
- SPRITE_W, 16: sprite width used for clamping.
- SPRITE_H, 16: sprite height used for clamping.
- STEP, 1: pixels moved per frame (1..15).
- PASS_TIMEOUT, 1023: maximum cycles allowed per erase or draw pass.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- reset  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse that starts a frame update.
- dir  in  2  direction: 0 = up, 1 = down, 2 = left, 3 = right.
- dir_valid  in  1  when high, dir is sampled into the direction register.
- complete  in  1  sprite controller pass-complete level (high when idle).
- posx  in  8  sprite controller's reported x position.
- posy  in  7  sprite controller's reported y position.
- draw  out  1  sprite pass enable.
- clear  out  1  erase pass select (colour 0).
- shift_h  out  1  paint pass select.
- shift_v  out  1  held at 0.
- load  out  1  one-cycle position load strobe.
- shift_amount  out  7  held at 0.
- load_x  out  8  new x position, valid while load is high.
- load_y  out  7  new y position, valid while load is high.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame update.
- overrun  out  1  sticky; set when a frame_tick arrives while a tick is already pending.
- timeout_err  out  1  sticky; set when a pass exceeds PASS_TIMEOUT cycles.

## Operation
- States: IDLE, ERASE_ARM, ERASE, CALC, LOAD, DRAW_ARM, DRAW, DONE.
- Direction register:
  - Updated whenever dir_valid is high, in any state.
  - Resets to 3 (right).
  - A new dir sampled mid-frame takes effect in the next CALC.
- IDLE: advances to ERASE_ARM when frame_tick or pending is set. Entering ERASE_ARM clears pending.
- Pending flag:
  - Set when frame_tick arrives while busy.
  - A second tick while pending is already set sets overrun and is otherwise dropped.
- ERASE_ARM:
  - Outputs draw=1, clear=1.
  - Waits for complete=0, then goes to ERASE.
- ERASE:
  - Outputs draw=1, clear=1.
  - When complete=1 is seen, drops draw and clear on the next edge and goes to CALC.
- CALC:
  - Latches posx and posy.
  - Computes the new position in 9-bit arithmetic:
    - up: y = (posy < STEP) ? 0 : posy-STEP
    - down: y = min(posy+STEP, Y_MAX-SPRITE_H)
    - left: x = (posx < STEP) ? 0 : posx-STEP
    - right: x = min(posx+STEP, X_MAX-SPRITE_W)
  - The coordinate not being moved is unchanged.
- LOAD: outputs load=1 for exactly one cycle with load_x/load_y, then goes to DRAW_ARM.
- DRAW_ARM and DRAW:
  - Same sequence as ERASE_ARM and ERASE, but with shift_h=1 and clear=0.
  - Then goes to DONE.
- DONE: pulses frame_done for one cycle, then goes to IDLE.
- Pass timeout:
  - The cycle counter resets on entry to each ARM state and counts through ARM and pass states.
  - When it reaches PASS_TIMEOUT: set timeout_err, drop draw/clear/shift_h, and go to the next state (CALC after erase, DONE after draw).
- Exactly one of clear or shift_h is high whenever draw is high. load is never high while draw is high.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, including overrun and timeout_err. load_x and load_y are 0. State is IDLE, pending is 0, direction is 3.
- Reset mid-pass drops draw, clear and shift_h on the next edge. The sprite controller's pointer is not our concern.
- Latency: frame_tick in cycle N gives draw=1 in cycle N+1.
- Normal-case timing:
  - The sprite pass takes about 511 cycles.
  - draw falls 1 cycle after complete is seen high.
  - CALC takes 1 cycle and LOAD takes 1 cycle.
  - frame_done fires 1 cycle after the draw pass ends.
- Simultaneous events:
  - A frame_tick in the same cycle as DONE→IDLE is taken as pending, so IDLE starts immediately the next cycle.
  - If dir_valid and CALC occur in the same cycle, CALC uses the old direction.

## Test plan
- Reset, then one frame_tick with a sprite model whose pass lasts 511 cycles, posx=49, posy=48, dir=3. Required: an erase pass with clear=1; then load with load_x=50, load_y=48; then a pass with shift_h=1; then frame_done once; busy=0 after.
- Clamp checks:
  - posx=144, dir=3, STEP=1: load_x=144.
  - posx=0, dir=2: load_x=0.
  - posy=0, dir=0: load_y=0.
  - posy=104, dir=1: load_y=104.
- frame_tick twice during a draw pass. Required: overrun=1. Exactly one extra frame runs, starting the cycle after DONE.
- Sprite model holds complete=1 forever. Required: timeout_err=1 after 1023 cycles in ERASE_ARM, then CALC; the draw pass also times out; frame_done still pulses.
- reset asserted for 1 cycle mid-ERASE. Required: draw=0 and clear=0 the next cycle, state IDLE, sticky flags 0.
- dir changes from 3 to 0 with dir_valid during ERASE, posy=48. Required: load_y=47 and load_x unchanged.
